// File: rtl/uart_tx_arbiter_if.sv
// Requester-side handshake bundle for the shared UART transmitter.
// Requester i presents its byte at req_data[8i+7:8i].
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one 8N1 UART transmitter from NUM_REQ byte sources.
//   state | meaning
//   IDLE  | line high, grant offered to next requester in round-robin order
//   START | start bit (0) for BAUD_DIV cycles
//   DATA  | 8 data bits LSB first, BAUD_DIV cycles each
//   STOP  | stop bit (1) for BAUD_DIV cycles, then back to IDLE
module uart_tx_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int BAUD_DIV = 868,
  localparam int ID_W    = $clog2(NUM_REQ),
  localparam int CNT_W   = $clog2(BAUD_DIV)
) (
  input  logic            clk_in,
  input  logic            reset,
  input  logic            enable,
  uart_tx_arbiter_if.slave req_if,
  output logic            uart_tx,
  output logic            busy,
  output logic [ID_W-1:0] grant_id
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_cnt_nxt;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic [7:0]       data_q;
  logic             tx_q, tx_nxt;
  logic             baud_last;

  logic             found;
  logic [ID_W-1:0]  winner;
  logic             grant;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = grant_id;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int idx;
      idx = int'(grant_id) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_if.req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  // Gating with reset keeps req_ready quiet while reset is held low.
  assign grant            = (state == IDLE) && enable && reset && found;
  assign req_if.req_ready = grant ? (NUM_REQ'(1) << winner) : '0;

  assign baud_last = (baud_cnt == CNT_W'(BAUD_DIV - 1));

  always_comb begin
    state_nxt    = state;
    baud_cnt_nxt = baud_cnt;
    bit_idx_nxt  = bit_idx;
    case (state)
      IDLE: begin
        baud_cnt_nxt = '0;
        bit_idx_nxt  = '0;
        if (grant) state_nxt = START;
      end
      START: begin
        if (baud_last) begin
          state_nxt    = DATA;
          baud_cnt_nxt = '0;
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (baud_last) begin
          baud_cnt_nxt = '0;
          bit_idx_nxt  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_nxt = STOP;
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (baud_last) begin
          state_nxt    = IDLE;
          baud_cnt_nxt = '0;
        end else begin
          baud_cnt_nxt = baud_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Line level is precomputed from the next state so the pin comes straight off a flop.
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = data_q[bit_idx_nxt];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      tx_q     <= 1'b1;
      data_q   <= '0;
      grant_id <= ID_W'(NUM_REQ - 1);
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_cnt_nxt;
      bit_idx  <= bit_idx_nxt;
      tx_q     <= tx_nxt;
      if (grant) begin
        data_q   <= req_if.req_data[8*int'(winner) +: 8];
        grant_id <= winner;
      end
    end
  end

  assign uart_tx = tx_q;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_REQ=4, BAUD_DIV=4.
// Table of arbitration steps plus hand sequences for enable drop and mid-frame reset.
module tb_uart_tx_arbiter;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       enable;
  logic       uart_tx;
  logic       busy;
  logic [1:0] grant_id;

  int total = 0;
  int bad   = 0;

  logic [7:0] dat [4];

  uart_tx_arbiter_if #(.NUM_REQ(4)) req_if ();

  uart_tx_arbiter #(.NUM_REQ(4), .BAUD_DIV(4)) dut (
    .clk_in   (clk_in),
    .reset    (reset),
    .enable   (enable),
    .req_if   (req_if),
    .uart_tx  (uart_tx),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0] valid;
    logic       en;
    logic [3:0] exp_ready;
    logic [1:0] exp_gid;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Walks ncyc cycles of a frame starting at its first START cycle.
  task automatic run_frame(input logic [7:0] b, input logic [1:0] gid, input int ncyc, input int drop_at);
    logic exp_tx;
    for (int c = 0; c < ncyc; c++) begin
      if (c < 4)        exp_tx = 1'b0;
      else if (c >= 36) exp_tx = 1'b1;
      else              exp_tx = b[(c-4)/4];
      if (c == drop_at) enable = 1'b0;
      chk($sformatf("frame_tx c%0d", c), 32'(uart_tx), 32'(exp_tx));
      chk($sformatf("frame_busy c%0d", c), 32'(busy), 32'd1);
      chk($sformatf("frame_ready c%0d", c), 32'(req_if.req_ready), 32'd0);
      if (c == 0) chk("frame_grant_id", 32'(grant_id), 32'(gid));
      tick();
    end
  endtask

  initial begin
    dat[0] = 8'hA5; dat[1] = 8'h3C; dat[2] = 8'h0F; dat[3] = 8'h81;
    req_if.req_data  = {dat[3], dat[2], dat[1], dat[0]};
    req_if.req_valid = 4'b1111;
    enable = 1'b1;
    reset  = 1'b0;

    vecs[0]  = '{4'b0001, 1'b1, 4'b0001, 2'd0};
    vecs[1]  = '{4'b0101, 1'b1, 4'b0100, 2'd2};
    vecs[2]  = '{4'b0101, 1'b1, 4'b0001, 2'd0};
    vecs[3]  = '{4'b0010, 1'b0, 4'b0000, 2'd0};
    vecs[4]  = '{4'b1111, 1'b1, 4'b0010, 2'd1};
    vecs[5]  = '{4'b1111, 1'b1, 4'b0100, 2'd2};
    vecs[6]  = '{4'b1111, 1'b1, 4'b1000, 2'd3};
    vecs[7]  = '{4'b1111, 1'b1, 4'b0001, 2'd0};
    vecs[8]  = '{4'b1111, 1'b1, 4'b0010, 2'd1};
    vecs[9]  = '{4'b0000, 1'b1, 4'b0000, 2'd1};
    vecs[10] = '{4'b1001, 1'b1, 4'b1000, 2'd3};

    #22;
    chk("rst_tx", 32'(uart_tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_if.req_ready), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd3);
    tick();
    reset = 1'b1;

    for (int i = 0; i < 11; i++) begin
      req_if.req_valid = vecs[i].valid;
      enable           = vecs[i].en;
      #1;
      chk($sformatf("rec%0d_ready", i), 32'(req_if.req_ready), 32'(vecs[i].exp_ready));
      chk($sformatf("rec%0d_idle_busy", i), 32'(busy), 32'd0);
      chk($sformatf("rec%0d_idle_tx", i), 32'(uart_tx), 32'd1);
      tick();
      if (vecs[i].exp_ready != 4'b0000) begin
        run_frame(dat[vecs[i].exp_gid], vecs[i].exp_gid, 40, -1);
      end else begin
        for (int c = 0; c < 8; c++) begin
          chk($sformatf("rec%0d_hold_busy", i), 32'(busy), 32'd0);
          chk($sformatf("rec%0d_hold_tx", i), 32'(uart_tx), 32'd1);
          chk($sformatf("rec%0d_hold_ready", i), 32'(req_if.req_ready), 32'd0);
          tick();
        end
        chk($sformatf("rec%0d_grant_id", i), 32'(grant_id), 32'(vecs[i].exp_gid));
      end
    end

    // Enable dropped in the middle of DATA: frame finishes, nothing further granted.
    req_if.req_valid = 4'b0010;
    enable = 1'b1;
    #1;
    chk("en_drop_ready", 32'(req_if.req_ready), 32'b0010);
    tick();
    run_frame(dat[1], 2'd1, 40, 10);
    for (int c = 0; c < 10; c++) begin
      chk("en_off_ready", 32'(req_if.req_ready), 32'd0);
      chk("en_off_busy", 32'(busy), 32'd0);
      chk("en_off_tx", 32'(uart_tx), 32'd1);
      tick();
    end

    // Reset asserted during DATA bit 3 of requester 0's frame.
    enable = 1'b1;
    req_if.req_valid = 4'b0001;
    #1;
    chk("mid_rst_ready", 32'(req_if.req_ready), 32'b0001);
    tick();
    run_frame(dat[0], 2'd0, 17, -1);
    chk("pre_rst_tx_bit3", 32'(uart_tx), 32'd0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    req_if.req_valid = 4'b0011;
    #1 reset = 1'b0;
    #1;
    chk("async_rst_tx", 32'(uart_tx), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_ready", 32'(req_if.req_ready), 32'd0);
    chk("async_rst_grant_id", 32'(grant_id), 32'd3);
    #2 reset = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_if.req_ready), 32'b0001);
    tick();
    run_frame(dat[0], 2'd0, 40, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing the UART TX pin (2..8).
REQ-002 SHALL have parameter BAUD_DIV, default 868, clk_in cycles per UART bit (>=2).
REQ-003 SHALL have port clk_in  input  1  the single clock; all logic rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  when 1, new grants are permitted.
REQ-006 SHALL have port req_valid  input  NUM_REQ  per-requester byte-available flag.
REQ-007 SHALL have port req_data  input  NUM_REQ*8  requester i byte at bits [8i+7:8i].
REQ-008 SHALL have port req_ready  output  NUM_REQ  one-hot accept strobe.
REQ-009 SHALL have port uart_tx  output  1  serial line to the pad.
REQ-010 SHALL have port busy  output  1  high while a frame is in flight.
REQ-011 SHALL have port grant_id  output  clog2(NUM_REQ)  index of the last granted requester.

Function
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-013 In IDLE with enable=1 and any req_valid=1, SHALL assert req_ready for exactly one cycle, only to the winner, combinationally in that same cycle.
REQ-014 In the same cycle, SHALL latch the winner's byte and update grant_id; SHALL enter START on the next edge.
REQ-015 Arbitration SHALL be round-robin: search begins at grant_id+1 modulo NUM_REQ, and the first valid index wins.
REQ-016 req_ready SHALL be all-zero outside IDLE, when enable=0, and when no valid is present.
REQ-017 Requesters SHALL hold req_valid and req_data stable until ready; the block does not check this.
REQ-018 A baud counter SHALL count 0..BAUD_DIV-1 in each of START, DATA and STOP, and reset to 0 on every bit transition.
REQ-019 START: uart_tx=0 for BAUD_DIV cycles.
REQ-020 DATA: 8 bits LSB first, each BAUD_DIV cycles, with a 3-bit index that wraps 7 to STOP.
REQ-021 STOP: uart_tx=1 for BAUD_DIV cycles, then IDLE.
REQ-022 IDLE: uart_tx=1.
REQ-023 A frame SHALL occupy exactly 10*BAUD_DIV cycles from the first START cycle to the last STOP cycle.
REQ-024 Minimum gap between consecutive frames SHALL be one IDLE cycle, with uart_tx=1.
REQ-025 busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-026 Deasserting enable mid-frame SHALL NOT abort the frame; grants stop only from the next IDLE onward.
REQ-027 Changes to req_valid mid-frame SHALL NOT affect the frame in flight; arbitration uses IDLE-cycle values only.
REQ-028 uart_tx SHALL be driven from a flop, with no combinational glitches.

Reset
REQ-029 On reset=0, the FSM SHALL go to IDLE immediately (asynchronously), even mid-frame.
REQ-030 On reset=0, the baud counter and bit index SHALL clear.
REQ-031 On reset=0, uart_tx SHALL be 1, busy 0, and req_ready 0.
REQ-032 On reset=0, grant_id SHALL be NUM_REQ-1, so requester 0 has first priority.
REQ-033 Reset release SHALL take effect on the first clk_in edge after reset=1; the earliest grant is possible in that cycle.

Verification
REQ-034 Bench SHALL run with BAUD_DIV=4 and NUM_REQ=4 for all scenarios below.
REQ-035 Single byte: req_valid=0001, data0=0xA5 -> req_ready=0001 for 1 cycle; uart_tx sequence per 4-cycle bit = 0,1,0,1,0,0,1,0,1,1; busy high 40 cycles; grant_id=0.
REQ-036 All requesters: valid=1111 held -> grants 0,1,2,3,0 in order; each frame 40 cycles, separated by 1 idle cycle.
REQ-037 Fairness: after grant_id=2, valid=0101 -> requester 0 granted next, not 2.
REQ-038 Enable: enable=0 with valid=0010 -> no ready, uart_tx=1 indefinitely; enable dropped during DATA -> frame completes and no further grant.
REQ-039 Reset mid-frame: reset=0 asserted in DATA bit 3 -> uart_tx=1 and busy=0 without waiting for an edge; after release, grant_id=3 and requester 0 wins first.
